// File: rtl/tdm_demux1x8_if.sv
// ============================================================================
// Module   : tdm_demux1x8_if
// Brief    : Serial TDM input and demultiplexed frame output bundle
//            (slot width follows TDM_PARITY_EN)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface tdm_demux1x8_if;
`ifdef TDM_PARITY_EN
  localparam int SLOT_W = 4;
`else
  localparam int SLOT_W = 3;
`endif

  logic              din;
  logic              din_valid;
  logic              frame_sync;
  logic [7:0]        y;
  logic              y_valid;
  logic [SLOT_W-1:0] slot;
  logic              frame_err;
  logic              locked;

  modport master (
    output din, din_valid, frame_sync,
    input  y, y_valid, slot, frame_err, locked
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output y, y_valid, slot, frame_err, locked
  );
endinterface

`default_nettype wire

// File: rtl/tdm_demux1x8.sv
// ============================================================================
// Module   : tdm_demux1x8
// Brief    : 1-to-8 TDM serial demultiplexer with frame hunt/lock, idle
//            timeout and optional even-parity slot (macro TDM_PARITY_EN)
// Revision : 1.0
// ============================================================================
`default_nettype none

module tdm_demux1x8 #(
  parameter int IDLE_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  tdm_demux1x8_if.slave bus
);

`ifdef TDM_PARITY_EN
  localparam int SLOT_W = 4;
  localparam int SH_W   = 8;
`else
  localparam int SLOT_W = 3;
  localparam int SH_W   = 7;
`endif
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SH_W);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [7:0]        IDLE_LAST = 8'(IDLE_MAX - 1);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t            state, state_n;
  logic [SH_W-1:0]   shadow, shadow_n;
  logic [SLOT_W-1:0] slot_q, slot_n;
  logic [7:0]        idle, idle_n;
  logic [7:0]        y_q, y_n;
  logic              y_valid_q, y_valid_n;
  logic              frame_err_q, frame_err_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      shadow      <= '0;
      slot_q      <= '0;
      idle        <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state       <= state_n;
      shadow      <= shadow_n;
      slot_q      <= slot_n;
      idle        <= idle_n;
      y_q         <= y_n;
      y_valid_q   <= y_valid_n;
      frame_err_q <= frame_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    shadow_n    = shadow;
    slot_n      = slot_q;
    idle_n      = idle;
    y_n         = y_q;
    y_valid_n   = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      HUNT: begin
        idle_n = '0;
        slot_n = '0;
        if (bus.din_valid && bus.frame_sync) begin
          shadow_n[0] = bus.din;
          slot_n      = SLOT_ONE;
          state_n     = COLLECT;
        end
      end
      COLLECT: begin
        if (!bus.din_valid) begin
          if (idle == IDLE_LAST) begin
            frame_err_n = 1'b1;
            state_n     = HUNT;
            slot_n      = '0;
            idle_n      = '0;
          end else begin
            idle_n = idle + 8'd1;
          end
        end else begin
          idle_n = '0;
          if (bus.frame_sync) begin
            // Sync anywhere but slot 0 restarts the frame with this bit.
            frame_err_n = (slot_q != '0);
            shadow_n[0] = bus.din;
            slot_n      = SLOT_ONE;
          end else if (slot_q == '0) begin
            frame_err_n = 1'b1;
            state_n     = HUNT;
          end else if (slot_q == LAST_SLOT) begin
            slot_n = '0;
`ifdef TDM_PARITY_EN
            if (bus.din == ^shadow) begin
              y_n       = shadow;
              y_valid_n = 1'b1;
            end else begin
              frame_err_n = 1'b1;
            end
`else
            y_n       = {bus.din, shadow};
            y_valid_n = 1'b1;
`endif
          end else begin
            shadow_n[slot_q[2:0]] = bus.din;
            slot_n                = slot_q + SLOT_ONE;
          end
        end
      end
      default: state_n = HUNT;
    endcase
  end

  assign bus.y         = y_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.slot      = slot_q;
  assign bus.frame_err = frame_err_q;
  assign bus.locked    = (state == COLLECT);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux1x8.sv
// ============================================================================
// Module   : tb_tdm_demux1x8
// Brief    : Self-checking bench for tdm_demux1x8 with a queue-based frame model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tdm_demux1x8;
  localparam int IDLE_MAX = 16;
`ifdef TDM_PARITY_EN
  localparam int NS = 9;
`else
  localparam int NS = 8;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tdm_demux1x8_if bus ();
  tdm_demux1x8 #(.IDLE_MAX(IDLE_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Model: bits of the frame in progress, lock flag, idle count, last frame.
  bit         mq[$];
  logic       m_locked = 1'b0;
  int         m_idle = 0;
  logic [7:0] m_y = 8'h00;
  logic       m_yv = 1'b0;
  logic       m_fe = 1'b0;

  task automatic tick(input logic r, input logic d, input logic v, input logic fs);
    logic [7:0] f;
    rst = r; bus.din = d; bus.din_valid = v; bus.frame_sync = fs;
    @(posedge clk);
    m_yv = 1'b0; m_fe = 1'b0;
    if (r) begin
      m_locked = 1'b0; mq.delete(); m_idle = 0; m_y = 8'h00;
    end else if (!m_locked) begin
      if (v && fs) begin mq.delete(); mq.push_back(d); m_locked = 1'b1; end
    end else if (!v) begin
      m_idle++;
      if (m_idle == IDLE_MAX) begin m_fe = 1'b1; m_locked = 1'b0; mq.delete(); m_idle = 0; end
    end else begin
      m_idle = 0;
      if (fs) begin
        m_fe = (mq.size() != 0); mq.delete(); mq.push_back(d);
      end else if (mq.size() == 0) begin
        m_fe = 1'b1; m_locked = 1'b0;
      end else begin
        mq.push_back(d);
        if (mq.size() == NS) begin
          for (int k = 0; k < 8; k++) f[k] = mq[k];
          if (NS == 9 && mq[NS-1] != ^f) m_fe = 1'b1;
          else begin m_y = f; m_yv = 1'b1; end
          mq.delete();
        end
      end
    end
    #1;
  endtask

  // Sends one frame (plus parity slot when enabled), `gap` idle cycles before each bit.
  task automatic send_frame(input logic [7:0] b, input int gap, input logic bad_par);
    for (int k = 0; k < NS; k++) begin
      for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (k < 8) tick(1'b0, b[k], 1'b1, k == 0);
      else       tick(1'b0, (^b) ^ bad_par, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.y !== 8'h00 || bus.y_valid !== 1'b0 || bus.frame_err !== 1'b0 ||
        bus.locked !== 1'b0 || int'(bus.slot) !== 0) begin
      errors++;
      $display("FAIL reset: y=%h yv=%b fe=%b locked=%b slot=%0d, required 00/0/0/0/0",
               bus.y, bus.y_valid, bus.frame_err, bus.locked, bus.slot);
    end
  endtask

  task automatic test_basic;
    send_frame(8'h4D, 0, 1'b0);
    checks++;
    if (bus.y_valid !== 1'b1 || bus.y !== 8'h4D || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL basic_frame: y=%h yv=%b locked=%b, required 4d/1/1", bus.y, bus.y_valid, bus.locked);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.y_valid !== 1'b0 || bus.y !== 8'h4D || int'(bus.slot) !== 0) begin
      errors++;
      $display("FAIL basic_pulse: yv=%b y=%h slot=%0d, required 0/4d/0", bus.y_valid, bus.y, bus.slot);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] fr [2] = '{8'hA5, 8'h3C};
    int nyv = 0;
    int nfe = 0;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NS; k++) begin
        for (int g = 0; g < 3; g++) begin
          tick(1'b0, 1'b0, 1'b0, 1'b0);
          nyv += int'(bus.y_valid); nfe += int'(bus.frame_err);
        end
        if (k < 8) tick(1'b0, fr[f][k], 1'b1, k == 0);
        else       tick(1'b0, ^fr[f], 1'b1, 1'b0);
        nyv += int'(bus.y_valid); nfe += int'(bus.frame_err);
      end
      checks++;
      if (bus.y_valid !== 1'b1 || bus.y !== fr[f]) begin
        errors++;
        $display("FAIL b2b_frame%0d: y=%h yv=%b, required %h/1", f, bus.y, bus.y_valid, fr[f]);
      end
    end
    checks++;
    if (nyv != 2 || nfe != 0) begin
      errors++;
      $display("FAIL b2b_counts: y_valid=%0d frame_err=%0d, required 2/0", nyv, nfe);
    end
  endtask

  task automatic test_early_sync;
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b1, k == 0);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.y !== 8'h3C || int'(bus.slot) !== 1 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL early_sync: fe=%b y=%h slot=%0d locked=%b, required 1/3c/1/1",
               bus.frame_err, bus.y, bus.slot, bus.locked);
    end
    for (int k = 1; k < NS; k++) tick(1'b0, (k < 8) ? 1'b1 : 1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.y_valid !== 1'b1 || bus.y !== 8'hFF || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL early_sync_next: y=%h yv=%b fe=%b, required ff/1/0", bus.y, bus.y_valid, bus.frame_err);
    end
  endtask

  task automatic test_idle_timeout;
    int early = 0;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= IDLE_MAX; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (i < IDLE_MAX && (bus.frame_err !== 1'b0 || bus.locked !== 1'b1)) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL idle_early: premature timeout cycles=%0d, required 0", early);
    end
    checks++;
    if (bus.frame_err !== 1'b1 || bus.locked !== 1'b0 || int'(bus.slot) !== 0) begin
      errors++;
      $display("FAIL idle_timeout: fe=%b locked=%b slot=%0d, required 1/0/0", bus.frame_err, bus.locked, bus.slot);
    end
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.locked !== 1'b0 || int'(bus.slot) !== 0 || bus.frame_err !== 1'b0 || bus.y !== 8'hFF) begin
      errors++;
      $display("FAIL idle_hunt: locked=%b slot=%0d fe=%b y=%h, required 0/0/0/ff",
               bus.locked, bus.slot, bus.frame_err, bus.y);
    end
  endtask

`ifdef TDM_PARITY_EN
  task automatic test_parity;
    send_frame(8'h4D, 0, 1'b0);
    checks++;
    if (bus.y_valid !== 1'b1 || bus.y !== 8'h4D) begin
      errors++;
      $display("FAIL parity_good: y=%h yv=%b, required 4d/1", bus.y, bus.y_valid);
    end
    send_frame(8'h3C, 0, 1'b0);
    send_frame(8'h4D, 0, 1'b1);
    checks++;
    if (bus.frame_err !== 1'b1 || bus.y_valid !== 1'b0 || bus.y !== 8'h3C ||
        bus.locked !== 1'b1 || int'(bus.slot) !== 0) begin
      errors++;
      $display("FAIL parity_bad: fe=%b yv=%b y=%h locked=%b slot=%0d, required 1/0/3c/1/0",
               bus.frame_err, bus.y_valid, bus.y, bus.locked, bus.slot);
    end
  endtask
`endif

  task automatic test_reset_mid;
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b1, k == 0);
    checks++;
    if (int'(bus.slot) !== 5) begin
      errors++;
      $display("FAIL mid_slot: slot=%0d, required 5", bus.slot);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.y_valid !== 1'b0 || bus.frame_err !== 1'b0 || bus.y !== 8'h00 ||
        int'(bus.slot) !== 0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: yv=%b fe=%b y=%h slot=%0d locked=%b, required 0/0/00/0/0",
               bus.y_valid, bus.frame_err, bus.y, bus.slot, bus.locked);
    end
  endtask

  task automatic test_random;
    int bad = 0;
    int both = 0;
    int burst = 0;
    logic v, fs;
    for (int i = 0; i < 4000; i++) begin
      if (burst > 0) begin
        burst--; v = 1'b0;
      end else begin
        if ($urandom_range(0, 199) == 0) burst = $urandom_range(10, 24);
        v = ($urandom_range(0, 3) != 0);
      end
      fs = (mq.size() == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 39) == 0);
      tick($urandom_range(0, 999) == 0, 1'($urandom), v, fs);
      checks++;
      if (bus.y_valid !== m_yv || bus.frame_err !== m_fe || bus.y !== m_y ||
          bus.locked !== m_locked || int'(bus.slot) !== mq.size()) begin
        errors++;
        if (bad < 10)
          $display("FAIL random@%0d: yv=%b fe=%b y=%h locked=%b slot=%0d, required %b/%b/%h/%b/%0d",
                   i, bus.y_valid, bus.frame_err, bus.y, bus.locked, bus.slot,
                   m_yv, m_fe, m_y, m_locked, mq.size());
        bad++;
      end
      if (bus.y_valid === 1'b1 && bus.frame_err === 1'b1) both++;
    end
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL pulse_overlap: cycles=%0d, required 0", both);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_early_sync();
    test_idle_timeout();
`ifdef TDM_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
